// File: rtl/calc_pkg.sv
// Shared key-code constants, debounce state type and key classification helpers
// for the keypad entry path.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_CLR = 4'd14;
  localparam logic [3:0] KEY_EQ  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } deb_state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  // CLR is the only non-digit key that does not hand off an operand.
  function automatic logic is_op(input logic [3:0] k);
    return (k >= KEY_ADD) && (k != KEY_CLR);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Press/release debouncer: emits a one-cycle accept with the key code once per
// physical press that stays stable for DEBOUNCE_CYCLES samples.
//
// state           | meaning
// ST_IDLE         | no key present, waiting for KeyRead
// ST_PRESS_WAIT   | key present, counting stable samples of cand_key
// ST_HELD         | press accepted, waiting for release
// ST_RELEASE_WAIT | key absent, counting stable release samples
module key_debounce
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] BCDKey,
  input  logic       KeyRead,
  output logic       accept,
  output logic [3:0] acc_key
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  deb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       cand_key, cand_nxt;
  logic             accept_nxt;
  logic [3:0]       acc_key_nxt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cand_key <= '0;
      accept   <= 1'b0;
      acc_key  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cand_key <= cand_nxt;
      accept   <= accept_nxt;
      acc_key  <= acc_key_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cand_nxt    = cand_key;
    accept_nxt  = 1'b0;
    acc_key_nxt = acc_key;
    case (state)
      ST_IDLE: begin
        if (KeyRead) begin
          cand_nxt  = BCDKey;
          cnt_nxt   = '0;
          state_nxt = ST_PRESS_WAIT;
        end
      end
      ST_PRESS_WAIT: begin
        if (!KeyRead) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else if (BCDKey != cand_key) begin
          cand_nxt = BCDKey;
          cnt_nxt  = '0;
        end else if (cnt == CNT_TC) begin
          accept_nxt  = 1'b1;
          acc_key_nxt = cand_key;
          state_nxt   = ST_HELD;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!KeyRead) begin
          cnt_nxt   = '0;
          state_nxt = ST_RELEASE_WAIT;
        end
      end
      ST_RELEASE_WAIT: begin
        // A return of KeyRead here is contact bounce, not a new press.
        if (KeyRead) begin
          state_nxt = ST_HELD;
        end else if (cnt == CNT_TC) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/key_entry.sv
// Keypad entry: shifts debounced digit keys into a packed-BCD register and hands
// the operand plus operator code to the calculator core with a one-cycle strobe.
module key_entry
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int NUM_DIGITS      = 4
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [3:0]                       BCDKey,
  input  logic                             KeyRead,
  output logic [4*NUM_DIGITS-1:0]          entry,
  output logic [$clog2(NUM_DIGITS+1)-1:0]  digit_count,
  output logic [4*NUM_DIGITS-1:0]          operand,
  output logic [3:0]                       op_code,
  output logic                             op_valid,
  output logic                             entry_full
);

  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic       accept;
  logic [3:0] acc_key;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .CLK    (CLK),
    .RESET  (RESET),
    .BCDKey (BCDKey),
    .KeyRead(KeyRead),
    .accept (accept),
    .acc_key(acc_key)
  );

  assign entry_full = (digit_count == CW'(NUM_DIGITS));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      entry       <= '0;
      digit_count <= '0;
      operand     <= '0;
      op_code     <= '0;
      op_valid    <= 1'b0;
    end else begin
      op_valid <= 1'b0;
      if (accept) begin
        if (is_digit(acc_key)) begin
          // Digits beyond capacity are dropped so the operand never truncates.
          if (!entry_full) begin
            entry       <= {entry[4*NUM_DIGITS-5:0], acc_key};
            digit_count <= digit_count + CW'(1);
          end
        end else if (is_op(acc_key)) begin
          operand     <= entry;
          op_code     <= acc_key;
          op_valid    <= 1'b1;
          entry       <= '0;
          digit_count <= '0;
        end else begin
          entry       <= '0;
          digit_count <= '0;
        end
      end
    end
  end

endmodule
